// File: rtl/flash_req_bridge.sv
// Purpose: single-outstanding CPU request bridge in front of the SPI flash engine (command hold, timeout, response).
// Latency: 1 accept + 1 check + N engine cycles + GAP_CYCLES + 1 response cycle; misaligned requests respond 2 cycles after accept.
// Backpressure: req_ready low from accept until the response is taken; rsp_* held stable while rsp_ready is low.
module flash_req_bridge #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [11:0] rsp_status,
  output logic        flash_en,
  output logic        flash_write,
  output logic [23:0] flash_addr,
  output logic [31:0] flash_data_in,
  input  logic [31:0] flash_data_out,
  input  logic [11:0] flash_state,
  input  logic        flash_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    BUSY  = 3'd2,
    GAP   = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0]  ERR_OK   = 2'b00;
  localparam logic [1:0]  ERR_MIS  = 2'b01;
  localparam logic [1:0]  ERR_TMO  = 2'b10;
  localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;
  localparam logic [2:0]  GAP_LAST = 3'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [11:0] rsp_status_q, rsp_status_d;
  logic        flash_en_q, flash_en_d;
  logic        flash_write_q, flash_write_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic [31:0] flash_data_in_q, flash_data_in_d;
  logic        lat_write_q, lat_write_d;
  logic [23:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]  gap_cnt_q, gap_cnt_d;

  // Next-state and next-output logic; every register holds unless its state updates it.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    rsp_status_d    = rsp_status_q;
    flash_en_d      = flash_en_q;
    flash_write_d   = flash_write_q;
    flash_addr_d    = flash_addr_q;
    flash_data_in_d = flash_data_in_q;
    lat_write_d     = lat_write_q;
    lat_addr_d      = lat_addr_q;
    lat_wdata_d     = lat_wdata_q;
    tmo_cnt_d       = tmo_cnt_q;
    gap_cnt_d       = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          req_ready_d = 1'b0;
          state_d     = CHECK;
        end
      end

      CHECK: begin
        if (lat_addr_q[1:0] != 2'b00) begin
          // Misaligned: answer directly, the engine never sees this request.
          rsp_err_d    = ERR_MIS;
          rsp_rdata_d  = 32'h0;
          rsp_status_d = 12'h0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          flash_addr_d    = lat_addr_q;
          flash_write_d   = lat_write_q;
          flash_data_in_d = lat_wdata_q;
          flash_en_d      = 1'b1;
          tmo_cnt_d       = 24'h0;
          state_d         = BUSY;
        end
      end

      BUSY: begin
        tmo_cnt_d = tmo_cnt_q + 24'd1;
        // Completion wins over a simultaneous timeout expiry.
        if (flash_ready) begin
          rsp_rdata_d  = lat_write_q ? 32'h0 : flash_data_out;
          rsp_status_d = flash_state;
          rsp_err_d    = ERR_OK;
          flash_en_d   = 1'b0;
          gap_cnt_d    = 3'h0;
          state_d      = GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_rdata_d  = 32'h0;
          rsp_status_d = flash_state;
          rsp_err_d    = ERR_TMO;
          flash_en_d   = 1'b0;
          gap_cnt_d    = 3'h0;
          state_d      = GAP;
        end
      end

      GAP: begin
        // Keep enable low long enough for the engine to return to idle with cs high.
        if (gap_cnt_q == GAP_LAST) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        flash_en_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any request in flight.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'h0;
      rsp_err_q       <= 2'b00;
      rsp_status_q    <= 12'h0;
      flash_en_q      <= 1'b0;
      flash_write_q   <= 1'b0;
      flash_addr_q    <= 24'h0;
      flash_data_in_q <= 32'h0;
      lat_write_q     <= 1'b0;
      lat_addr_q      <= 24'h0;
      lat_wdata_q     <= 32'h0;
      tmo_cnt_q       <= 24'h0;
      gap_cnt_q       <= 3'h0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      rsp_status_q    <= rsp_status_d;
      flash_en_q      <= flash_en_d;
      flash_write_q   <= flash_write_d;
      flash_addr_q    <= flash_addr_d;
      flash_data_in_q <= flash_data_in_d;
      lat_write_q     <= lat_write_d;
      lat_addr_q      <= lat_addr_d;
      lat_wdata_q     <= lat_wdata_d;
      tmo_cnt_q       <= tmo_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_status    = rsp_status_q;
  assign flash_en      = flash_en_q;
  assign flash_write   = flash_write_q;
  assign flash_addr    = flash_addr_q;
  assign flash_data_in = flash_data_in_q;

endmodule
